// File: rtl/neural_stream_core_if.sv
// Beat stream bundle for neural_stream_core: input beat channel, output beat channel and frame statistics.
// master drives beats in and accepts results; slave is the core.
interface neural_stream_core_if #(
    parameter int PIX_W = 8,
    parameter int CH    = 3,
    parameter int CNT_W = 16
);
    logic                  s_valid;
    logic                  s_ready;
    logic [2:0]            s_mode;
    logic [PIX_W-1:0]      s_param;
    logic [CH*PIX_W-1:0]   s_pix_a;
    logic [CH*PIX_W-1:0]   s_pix_b;
    logic                  s_last;

    logic                  m_valid;
    logic                  m_ready;
    logic [CH*PIX_W-1:0]   m_pix;
    logic                  m_last;

    logic [CNT_W-1:0]      stat_beats;
    logic [CNT_W-1:0]      stat_frames;

    modport master (
        output s_valid, s_mode, s_param, s_pix_a, s_pix_b, s_last, m_ready,
        input  s_ready, m_valid, m_pix, m_last, stat_beats, stat_frames
    );

    modport slave (
        input  s_valid, s_mode, s_param, s_pix_a, s_pix_b, s_last, m_ready,
        output s_ready, m_valid, m_pix, m_last, stat_beats, stat_frames
    );
endinterface

// File: rtl/neural_stream_core.sv
// Per-beat multi-channel pixel operator (blend/invert/brighten/darken/threshold/max/absdiff/bypass), 2-cycle latency.
// Both stages advance together when the output slot is empty or being drained; s_ready drops only when full and stalled.
module neural_stream_core #(
    parameter int PIX_W = 8,
    parameter int CH    = 3,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    neural_stream_core_if.slave io
);
    localparam int BW  = CH * PIX_W;
    localparam int PW2 = 2 * PIX_W;
    localparam logic [PIX_W-1:0] MAX  = '1;
    localparam logic [PW2:0]     HALF = (PW2 + 1)'(1) << (PIX_W - 1);

    typedef enum logic [2:0] {
        M_BLEND   = 3'b000,
        M_INVERT  = 3'b001,
        M_BRIGHT  = 3'b010,
        M_DARK    = 3'b011,
        M_THRESH  = 3'b100,
        M_MAX     = 3'b101,
        M_ABSDIFF = 3'b110,
        M_BYPASS  = 3'b111
    } mode_e;

    // Stage 1
    logic               v1_q;
    logic [BW-1:0]      a1_q;
    logic [BW-1:0]      b1_q;
    logic [PIX_W-1:0]   p1_q;
    mode_e              mode1_q;
    logic               last1_q;
    logic [CH*PW2-1:0]  pa1_q, pa_d;
    logic [CH*PW2-1:0]  pb1_q, pb_d;

    // Stage 2 / output
    logic               v2_q;
    logic [BW-1:0]      m_pix_q, res_d;
    logic               m_last_q;

    logic [CNT_W-1:0]   stat_beats_q, stat_beats_d;
    logic [CNT_W-1:0]   stat_frames_q, stat_frames_d;

    logic en;

    assign en         = !v2_q || io.m_ready;
    assign io.s_ready = en;
    assign io.m_valid = v2_q;
    assign io.m_pix   = m_pix_q;
    assign io.m_last  = m_last_q;
    assign io.stat_beats  = stat_beats_q;
    assign io.stat_frames = stat_frames_q;

    // Blend products are formed on the way into stage 1 so stage 2 only has to add and scale.
    always_comb begin
        pa_d = '0;
        pb_d = '0;
        for (int k = 0; k < CH; k++) begin
            pa_d[k*PW2 +: PW2] = PW2'(io.s_pix_a[k*PIX_W +: PIX_W]) * PW2'(io.s_param);
            pb_d[k*PW2 +: PW2] = PW2'(io.s_pix_b[k*PIX_W +: PIX_W]) * PW2'(MAX - io.s_param);
        end
    end

    always_comb begin
        logic [PIX_W-1:0] a, b, r;
        logic [PW2:0]     sum, scaled;
        logic [PIX_W:0]   bright;
        res_d  = '0;
        a      = '0;
        b      = '0;
        r      = '0;
        sum    = '0;
        scaled = '0;
        bright = '0;
        for (int k = 0; k < CH; k++) begin
            a = a1_q[k*PIX_W +: PIX_W];
            b = b1_q[k*PIX_W +: PIX_W];
            // (s + s/2^W) / 2^W approximates s/MAX with rounding from HALF; exact at p=0 and p=MAX.
            sum    = {1'b0, pa1_q[k*PW2 +: PW2]} + {1'b0, pb1_q[k*PW2 +: PW2]} + HALF;
            scaled = sum + (sum >> PIX_W);
            bright = {1'b0, a} + {1'b0, p1_q};
            case (mode1_q)
                M_BLEND:   r = scaled[PW2-1:PIX_W];
                M_INVERT:  r = MAX - a;
                M_BRIGHT:  r = bright[PIX_W] ? MAX : bright[PIX_W-1:0];
                M_DARK:    r = (a > p1_q) ? (a - p1_q) : '0;
                M_THRESH:  r = (a >= p1_q) ? MAX : '0;
                M_MAX:     r = (a >= b) ? a : b;
                M_ABSDIFF: r = (a >= b) ? (a - b) : (b - a);
                M_BYPASS:  r = a;
                default:   r = a;
            endcase
            res_d[k*PIX_W +: PIX_W] = r;
        end
    end

    always_comb begin
        stat_beats_d  = stat_beats_q;
        stat_frames_d = stat_frames_q;
        if (io.s_valid && en) begin
            stat_beats_d = io.s_last ? '0 : stat_beats_q + CNT_W'(1);
        end
        if (v2_q && io.m_ready && m_last_q) begin
            stat_frames_d = stat_frames_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q          <= 1'b0;
            a1_q          <= '0;
            b1_q          <= '0;
            p1_q          <= '0;
            mode1_q       <= M_BLEND;
            last1_q       <= 1'b0;
            pa1_q         <= '0;
            pb1_q         <= '0;
            v2_q          <= 1'b0;
            m_pix_q       <= '0;
            m_last_q      <= 1'b0;
            stat_beats_q  <= '0;
            stat_frames_q <= '0;
        end else begin
            if (en) begin
                v1_q     <= io.s_valid;
                a1_q     <= io.s_pix_a;
                b1_q     <= io.s_pix_b;
                p1_q     <= io.s_param;
                mode1_q  <= mode_e'(io.s_mode);
                last1_q  <= io.s_last;
                pa1_q    <= pa_d;
                pb1_q    <= pb_d;
                v2_q     <= v1_q;
                m_pix_q  <= res_d;
                m_last_q <= last1_q;
            end
            stat_beats_q  <= stat_beats_d;
            stat_frames_q <= stat_frames_d;
        end
    end
endmodule

// File: tb/tb_neural_stream_core.sv
// Directed bench for neural_stream_core: per-mode vector table, full-rate mixed modes,
// stalled streaming, frame statistics and mid-stream reset.
module tb_neural_stream_core;
    localparam int PIX_W = 8;
    localparam int CH    = 3;
    localparam int CNT_W = 16;
    localparam int BW    = CH * PIX_W;
    localparam int NVEC  = 13;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    neural_stream_core_if #(.PIX_W(PIX_W), .CH(CH), .CNT_W(CNT_W)) bus ();

    neural_stream_core #(.PIX_W(PIX_W), .CH(CH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    typedef struct {
        logic [2:0]       mode;
        logic [PIX_W-1:0] p;
        logic [BW-1:0]    a;
        logic [BW-1:0]    b;
        logic [BW-1:0]    res;
    } vec_t;

    vec_t vt [NVEC];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [BW-1:0] pk(input int c0, input int c1, input int c2);
        return {8'(c2), 8'(c1), 8'(c0)};
    endfunction

    task automatic drive(input vec_t v, input logic last);
        bus.s_valid = 1'b1;
        bus.s_mode  = v.mode;
        bus.s_param = v.p;
        bus.s_pix_a = v.a;
        bus.s_pix_b = v.b;
        bus.s_last  = last;
    endtask

    logic [15:0]   pat = 16'hB2E4;
    logic [BW-1:0] held;
    logic          held_v;
    int            sent, got;
    int            exp_beats  [11] = '{1, 2, 3, 4, 0, 1, 2, 0, 0, 0, 0};
    int            exp_frames [11] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 2};
    int            mix_idx    [4]  = '{0, 3, 4, 9};
    vec_t          bv;

    initial begin
        vt[0]  = '{3'b000, 8'd128, pk(200, 200, 200), pk(100, 100, 100), pk(150, 150, 150)};
        vt[1]  = '{3'b000, 8'd255, pk(200, 200, 200), pk(0, 0, 0),       pk(200, 200, 200)};
        vt[2]  = '{3'b000, 8'd0,   pk(0, 0, 0),       pk(77, 77, 77),    pk(77, 77, 77)};
        vt[3]  = '{3'b001, 8'd0,   pk(10, 0, 255),    pk(0, 0, 0),       pk(245, 255, 0)};
        vt[4]  = '{3'b010, 8'd100, pk(200, 155, 0),   pk(0, 0, 0),       pk(255, 255, 100)};
        vt[5]  = '{3'b011, 8'd100, pk(50, 100, 255),  pk(0, 0, 0),       pk(0, 0, 155)};
        vt[6]  = '{3'b100, 8'd128, pk(127, 128, 255), pk(0, 0, 0),       pk(0, 255, 255)};
        vt[7]  = '{3'b101, 8'd0,   pk(30, 90, 0),     pk(90, 30, 0),     pk(90, 90, 0)};
        vt[8]  = '{3'b110, 8'd0,   pk(30, 90, 5),     pk(90, 30, 5),     pk(60, 60, 0)};
        vt[9]  = '{3'b111, 8'd99,  pk(1, 2, 3),       pk(9, 9, 9),       pk(1, 2, 3)};
        vt[10] = '{3'b000, 8'd64,  pk(0, 255, 100),   pk(255, 0, 100),   pk(191, 64, 100)};
        vt[11] = '{3'b011, 8'd255, pk(255, 254, 0),   pk(0, 0, 0),       pk(0, 0, 0)};
        vt[12] = '{3'b110, 8'd0,   pk(0, 255, 17),    pk(255, 0, 18),    pk(255, 255, 1)};

        rst = 1'b1;
        bus.s_valid = 1'b0; bus.s_mode = 3'b0; bus.s_param = '0;
        bus.s_pix_a = '0;   bus.s_pix_b = '0;  bus.s_last = 1'b0;
        bus.m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_m_pix", 32'(bus.m_pix), 32'd0);
        chk("rst_m_last", 32'(bus.m_last), 32'd0);
        chk("rst_stat_beats", 32'(bus.stat_beats), 32'd0);
        chk("rst_stat_frames", 32'(bus.stat_frames), 32'd0);
        rst = 1'b0;

        // One isolated beat per vector: not valid one cycle after accept, valid the next.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vt[i], 1'b0);
            @(negedge clk);
            bus.s_valid = 1'b0;
            chk($sformatf("vec%0d_early_valid", i), 32'(bus.m_valid), 32'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 32'(bus.m_valid), 32'd1);
            chk($sformatf("vec%0d_pix", i), 32'(bus.m_pix), 32'(vt[i].res));
        end

        // Back-to-back beats of different modes, one result per cycle.
        @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            if (c >= 2) begin
                chk($sformatf("mix%0d_valid", c - 2), 32'(bus.m_valid), 32'd1);
                chk($sformatf("mix%0d_pix", c - 2), 32'(bus.m_pix), 32'(vt[mix_idx[c-2]].res));
            end
            if (c < 4) drive(vt[mix_idx[c]], 1'b0);
            else       bus.s_valid = 1'b0;
            @(negedge clk);
        end

        // Bypass stream 1..8 under a fixed stall pattern.
        bv = '{3'b111, 8'd0, '0, '0, '0};
        sent = 0; got = 0; held_v = 1'b0; held = '0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            @(negedge clk);
            if (held_v) begin
                chk("bp_hold_valid", 32'(bus.m_valid), 32'd1);
                chk("bp_hold_pix", 32'(bus.m_pix), 32'(held));
            end
            bus.m_ready = pat[cyc % 16];
            if (sent < 8) begin
                bv.a = pk(sent + 1, sent + 17, sent + 33);
                drive(bv, 1'b0);
            end else begin
                bus.s_valid = 1'b0;
            end
            #1;
            chk("bp_s_ready", 32'(bus.s_ready), 32'(!(bus.m_valid && !bus.m_ready)));
            if (bus.m_valid && bus.m_ready) begin
                chk($sformatf("bp_out%0d", got), 32'(bus.m_pix), 32'(pk(got + 1, got + 17, got + 33)));
                got++;
            end
            held_v = bus.m_valid && !bus.m_ready;
            held   = bus.m_pix;
            if (bus.s_valid && bus.s_ready) sent++;
        end
        chk("bp_received", 32'(got), 32'd8);
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_no_extra", 32'(bus.m_valid), 32'd0);
        end

        // Frames of 5 and 3 beats at full rate.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 11; n++) begin
            if (n < 8) begin
                bv.a = pk(n, n, n);
                drive(bv, (n == 4 || n == 7));
            end else begin
                bus.s_valid = 1'b0;
                bus.s_last  = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("stat_beats_%0d", n), 32'(bus.stat_beats), 32'(exp_beats[n]));
            chk($sformatf("stat_frames_%0d", n), 32'(bus.stat_frames), 32'(exp_frames[n]));
            chk($sformatf("m_last_%0d", n), 32'(bus.m_last), 32'(n == 5 || n == 8));
        end

        // Reset with two beats in flight.
        bv.a = pk(5, 6, 7);
        drive(bv, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        chk("pre_rst_beats", 32'(bus.stat_beats), 32'd2);
        chk("pre_rst_frames", 32'(bus.stat_frames), 32'd2);
        chk("pre_rst_valid", 32'(bus.m_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.m_valid), 32'd0);
        chk("mid_rst_beats", 32'(bus.stat_beats), 32'd0);
        chk("mid_rst_frames", 32'(bus.stat_frames), 32'd0);
        chk("mid_rst_pix", 32'(bus.m_pix), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 32'(bus.m_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/neural_stream_core.md
Name: neural_stream_core

Overview:
- Parametrised, streaming successor to the single-pixel neural mode core.
- Processes CH channels of PIX_W-bit pixels per beat through a 2-stage pipeline with valid/ready handshake and full backpressure.
- Mode and parameter travel with each beat.
- Adds darken, threshold, max and abs-diff modes, plus per-frame beat/frame statistics.
- Sits between the pixel fetch stream and the output formatter.

Parameters:
- PIX_W, 8, bits per channel sample; MAX = 2^PIX_W-1.
- CH, 3, channels per beat; buses are CH*PIX_W wide, channel k at bits [k*PIX_W +: PIX_W].
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  core can accept a beat.
- s_mode  in  3  operation for this beat.
- s_param  in  PIX_W  blend mask / brightness step / threshold, shared by all channels.
- s_pix_a  in  CH*PIX_W  primary pixel.
- s_pix_b  in  CH*PIX_W  secondary pixel (blend, max, absdiff).
- s_last  in  1  final beat of frame.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts.
- m_pix  out  CH*PIX_W  result.
- m_last  out  1  s_last delayed with its beat.
- stat_beats  out  CNT_W  beats accepted in the current input frame.
- stat_frames  out  CNT_W  frames completed at output.

Behaviour:
- Reset (async, rst=1): v1, v2, m_valid, m_last, m_pix, stat_beats, stat_frames all 0. Beats in flight are discarded.
- Handshake:
  - Transfer on s_valid&&s_ready and on m_valid&&m_ready.
  - en = !v2 || m_ready; s_ready = en (combinational from m_ready and state).
  - When en=0 both stages hold their contents.
  - m_pix and m_last must stay stable while m_valid && !m_ready.
- Stage 1 (on en):
  - Registers a, b, mode, last, v1 <= s_valid.
  - Computes the per-channel blend products pa = a*p and pb = b*(MAX-p), each 2*PIX_W bits.
- Stage 2 (on en):
  - v2 <= v1.
  - Computes the per-channel result and registers it into m_pix; also registers m_last.
  - m_valid = v2.
- Latency: 2 cycles from accepted beat to m_valid with m_ready held high. Throughput 1 beat/cycle.
- Mode function (per channel, unsigned):
  - 000 blend: s = pa + pb + 2^(PIX_W-1) (2*PIX_W+1 bits); r = (s + (s>>PIX_W)) >> PIX_W, truncated to PIX_W.
  - 001 invert: r = MAX - a.
  - 010 brighten: r = a + p, saturating at MAX.
  - 011 darken: r = a - p, saturating at 0.
  - 100 threshold: r = (a >= p) ? MAX : 0.
  - 101 max: r = max(a, b).
  - 110 absdiff: r = |a - b|.
  - 111 bypass: r = a.
- Statistics:
  - stat_beats increments on each accepted input beat. On an accepted beat with s_last=1 it resets to 0 instead.
  - stat_frames increments on each output handshake with m_last=1.
  - Both wrap modulo 2^CNT_W with no sticky flag.
- Boundaries:
  - Pipe full and m_ready=0: s_ready=0, and s_* inputs are ignored that cycle.
  - Simultaneous output drain and input accept in the same cycle: allowed, no bubble.
  - s_valid=0 beats create bubbles that propagate as v=0.
  - Mode changes between beats take effect per beat; there is no frame-level latching.
  - Blend with p=MAX returns a exactly; with p=0 returns b exactly.

Test Plan:
- Reset/idle: assert rst mid-stream with 2 beats in flight → m_valid=0, stats=0 immediately; no output after release until new input.
- Blend, PIX_W=8: a=200, b=100, p=128 → 150 on all channels 2 cycles later. a=200, b=0, p=255 → 200; a=0, b=77, p=0 → 77.
- Saturation/threshold:
  - brighten a=200, p=100 → 255; darken a=50, p=100 → 0.
  - threshold p=128: a=127 → 0, a=128 → 255.
  - invert a=10 → 245; absdiff a=30, b=90 → 60; max a=30, b=90 → 90.
- Backpressure: stream 8 beats (values 1..8, bypass) with m_ready toggling pseudo-randomly → outputs 1..8 in order, none lost or duplicated, m_pix stable while stalled, s_ready=0 only when v2=1 && m_ready=0.
- Frame stats: two frames of 5 and 3 beats with s_last on the final beat → stat_beats counts 1..4 then 0, then 1..2 then 0; stat_frames becomes 1 then 2, each change on the m_last handshake.
- Mixed modes per beat: consecutive beats blend/invert/brighten/bypass at full rate → each result matches its own beat's mode and param, with 1 beat/cycle throughput.
